// File: rtl/product_accumulator.sv
// Sums ACC_LEN unsigned 16-bit products into one frame result with a valid/ready handoff.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp on overflow; otherwise the sum wraps.
module product_accumulator #(
  parameter int ACC_LEN = 8,
  parameter int ACC_W   = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      in_prod,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [8:0]       out_cnt
);

  localparam logic [0:0]       ACCUM   = 1'b0;
  localparam logic [0:0]       HOLD    = 1'b1;
  localparam logic [8:0]       LEN     = 9'(ACC_LEN);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [8:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic [8:0]       out_cnt_q, out_cnt_d;

  logic             accept;
  logic             emit;
  logic             ovf_add;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_add;
  logic [8:0]       cnt_add;

  always_comb begin
    // in_ready_q is only ever high in ACCUM, so it doubles as the state qualifier
    accept  = in_valid && in_ready_q;
    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, in_prod};
    ovf_add = ovf_q | sum_ext[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    acc_add = ovf_add ? ACC_MAX : sum_ext[ACC_W-1:0];
`else
    acc_add = sum_ext[ACC_W-1:0];
`endif
    cnt_add = cnt_q + 9'd1;

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    out_cnt_d = out_cnt_q;
    emit      = 1'b0;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_add;
          ovf_d = ovf_add;
        end
        emit = (accept && (cnt_add == LEN)) || (flush && ((cnt_q != 9'd0) || accept));
        if (emit) begin
          out_sum_d = acc_d;
          out_cnt_d = cnt_d;
          out_ovf_d = ovf_d;
          state_d   = HOLD;
        end
      end
      default: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = 9'd0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
    endcase

    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ACCUM;
      in_ready_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= 9'd0;
      ovf_q      <= 1'b0;
      out_sum_q  <= '0;
      out_ovf_q  <= 1'b0;
      out_cnt_q  <= 9'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_sum_q  <= out_sum_d;
      out_ovf_q  <= out_ovf_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;

endmodule
